// File: rtl/axi_arb_pkg.sv
// Shared types for the two-requester AXI4 arbiter: per-direction FSM states
// and the requester count.
package axi_arb_pkg;
  localparam int NUM_REQUESTERS = 2;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} write_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} read_state_t;
endpackage

// File: rtl/axi4_interface.sv
// AXI4 bundle with m_ signals driven by the master side and s_ signals
// driven by the slave side.
interface axi4_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic [7:0]            m_awlen;
  logic                  m_awvalid;
  logic                  s_awready;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_wlast;
  logic                  m_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  m_bready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic                  m_arvalid;
  logic                  s_arready;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rlast;
  logic                  s_rvalid;
  logic                  m_rready;

  modport master (
    output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready,
           m_araddr, m_arlen, m_arvalid, m_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp,
           s_rlast, s_rvalid
  );

  modport slave (
    input  m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready,
           m_araddr, m_arlen, m_arvalid, m_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp,
           s_rlast, s_rvalid
  );
endinterface

// File: rtl/axi_rr_select.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the
// requester that did not win last time.
module axi_rr_select
  import axi_arb_pkg::*;
(
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic                      last,
  output logic [NUM_REQUESTERS-1:0] grant
);
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end
endmodule

// File: rtl/axi_bus_arbiter.sv
// Shares one AXI4 master port between two requesters; read and write paths
// arbitrate independently with one burst in flight per direction.
module axi_bus_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  axi4_interface.slave  axi_bus_s0,
  axi4_interface.slave  axi_bus_s1,
  axi4_interface.master axi_bus_m
);
  write_state_t wstate;
  read_state_t  rstate;
  logic         wgrant, rgrant;
  logic         wr_last, rd_last;
  logic [7:0]   beat_cnt;
  logic [NUM_REQUESTERS-1:0] aw_gnt, ar_gnt;

  axi_rr_select u_aw_sel (
    .req   ({axi_bus_s1.m_awvalid, axi_bus_s0.m_awvalid}),
    .last  (wr_last),
    .grant (aw_gnt)
  );

  axi_rr_select u_ar_sel (
    .req   ({axi_bus_s1.m_arvalid, axi_bus_s0.m_arvalid}),
    .last  (rd_last),
    .grant (ar_gnt)
  );

  logic [ADDR_WIDTH-1:0] sel_awaddr, sel_araddr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [7:0]            sel_awlen, sel_arlen;
  logic                  sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
  logic                  sel_arvalid, sel_rready;

  assign sel_awaddr  = wgrant ? axi_bus_s1.m_awaddr  : axi_bus_s0.m_awaddr;
  assign sel_awlen   = wgrant ? axi_bus_s1.m_awlen   : axi_bus_s0.m_awlen;
  assign sel_awvalid = wgrant ? axi_bus_s1.m_awvalid : axi_bus_s0.m_awvalid;
  assign sel_wdata   = wgrant ? axi_bus_s1.m_wdata   : axi_bus_s0.m_wdata;
  assign sel_wlast   = wgrant ? axi_bus_s1.m_wlast   : axi_bus_s0.m_wlast;
  assign sel_wvalid  = wgrant ? axi_bus_s1.m_wvalid  : axi_bus_s0.m_wvalid;
  assign sel_bready  = wgrant ? axi_bus_s1.m_bready  : axi_bus_s0.m_bready;
  assign sel_araddr  = rgrant ? axi_bus_s1.m_araddr  : axi_bus_s0.m_araddr;
  assign sel_arlen   = rgrant ? axi_bus_s1.m_arlen   : axi_bus_s0.m_arlen;
  assign sel_arvalid = rgrant ? axi_bus_s1.m_arvalid : axi_bus_s0.m_arvalid;
  assign sel_rready  = rgrant ? axi_bus_s1.m_rready  : axi_bus_s0.m_rready;

  // Write path: payload always muxed, handshakes gated by state and owner
  assign axi_bus_m.m_awaddr  = sel_awaddr;
  assign axi_bus_m.m_awlen   = sel_awlen;
  assign axi_bus_m.m_wdata   = sel_wdata;
  assign axi_bus_m.m_wlast   = sel_wlast;
  assign axi_bus_m.m_awvalid = (wstate == W_ADDR) && sel_awvalid;
  assign axi_bus_m.m_wvalid  = (wstate == W_DATA) && sel_wvalid;
  assign axi_bus_m.m_bready  = (wstate == W_RESP) && sel_bready;
  assign axi_bus_s0.s_awready = (wstate == W_ADDR) && !wgrant && axi_bus_m.s_awready;
  assign axi_bus_s1.s_awready = (wstate == W_ADDR) &&  wgrant && axi_bus_m.s_awready;
  assign axi_bus_s0.s_wready  = (wstate == W_DATA) && !wgrant && axi_bus_m.s_wready;
  assign axi_bus_s1.s_wready  = (wstate == W_DATA) &&  wgrant && axi_bus_m.s_wready;
  assign axi_bus_s0.s_bvalid  = (wstate == W_RESP) && !wgrant && axi_bus_m.s_bvalid;
  assign axi_bus_s1.s_bvalid  = (wstate == W_RESP) &&  wgrant && axi_bus_m.s_bvalid;
  assign axi_bus_s0.s_bresp   = axi_bus_m.s_bresp;
  assign axi_bus_s1.s_bresp   = axi_bus_m.s_bresp;

  // Read path
  assign axi_bus_m.m_araddr  = sel_araddr;
  assign axi_bus_m.m_arlen   = sel_arlen;
  assign axi_bus_m.m_arvalid = (rstate == R_ADDR) && sel_arvalid;
  assign axi_bus_m.m_rready  = (rstate == R_DATA) && sel_rready;
  assign axi_bus_s0.s_arready = (rstate == R_ADDR) && !rgrant && axi_bus_m.s_arready;
  assign axi_bus_s1.s_arready = (rstate == R_ADDR) &&  rgrant && axi_bus_m.s_arready;
  assign axi_bus_s0.s_rvalid  = (rstate == R_DATA) && !rgrant && axi_bus_m.s_rvalid;
  assign axi_bus_s1.s_rvalid  = (rstate == R_DATA) &&  rgrant && axi_bus_m.s_rvalid;
  assign axi_bus_s0.s_rdata   = axi_bus_m.s_rdata;
  assign axi_bus_s1.s_rdata   = axi_bus_m.s_rdata;
  assign axi_bus_s0.s_rresp   = axi_bus_m.s_rresp;
  assign axi_bus_s1.s_rresp   = axi_bus_m.s_rresp;
  assign axi_bus_s0.s_rlast   = axi_bus_m.s_rlast;
  assign axi_bus_s1.s_rlast   = axi_bus_m.s_rlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate  <= W_IDLE;
      wgrant  <= 1'b0;
      wr_last <= 1'b1;
    end else begin
      case (wstate)
        W_IDLE: if (|aw_gnt) begin
          wstate <= W_ADDR;
          wgrant <= aw_gnt[1];
        end
        W_ADDR: if (axi_bus_m.m_awvalid && axi_bus_m.s_awready) wstate <= W_DATA;
        W_DATA: if (axi_bus_m.m_wvalid && axi_bus_m.s_wready && sel_wlast) wstate <= W_RESP;
        W_RESP: if (axi_bus_m.s_bvalid && axi_bus_m.m_bready) begin
          wstate  <= W_IDLE;
          wr_last <= wgrant;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // beat_cnt holds beats remaining minus one, so arlen=255 runs the full 256
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate   <= R_IDLE;
      rgrant   <= 1'b0;
      rd_last  <= 1'b1;
      beat_cnt <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (|ar_gnt) begin
          rstate <= R_ADDR;
          rgrant <= ar_gnt[1];
        end
        R_ADDR: if (axi_bus_m.m_arvalid && axi_bus_m.s_arready) begin
          rstate   <= R_DATA;
          beat_cnt <= sel_arlen;
        end
        R_DATA: if (axi_bus_m.s_rvalid && axi_bus_m.m_rready) begin
          if (beat_cnt == 8'd0) begin
            rstate  <= R_IDLE;
            rd_last <= rgrant;
          end else begin
            beat_cnt <= beat_cnt - 8'd1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule
